// File: rtl/go_game_ctrl_pkg.sv
// rtl/go_game_ctrl_pkg.sv - shared types, state codes and move decode helpers for go_game_ctrl
// Contents: stone_t cell encoding, end_reason_t, FSM state codes, is_pass()/is_resign().
package go_game_ctrl_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BLACK = 2'b01,
    WHITE = 2'b10
  } stone_t;

  typedef enum logic [1:0] {
    END_NONE    = 2'b00,
    END_PASSES  = 2'b01,
    END_RESIGN  = 2'b10,
    END_TIMEOUT = 2'b11
  } end_reason_t;

  typedef logic [2:0] state_t;

  localparam state_t S_WAIT   = 3'd0;
  localparam state_t S_CHECK  = 3'd1;
  localparam state_t S_COMMIT = 3'd2;
  localparam state_t S_SEND   = 3'd3;
  localparam state_t S_PASS   = 3'd4;
  localparam state_t S_OVER   = 3'd5;

  // Moves are zero-extended to 16 bits; move_w is the real move width.
  function automatic logic is_pass(input logic [15:0] mv, input int move_w);
    logic [15:0] w_code;
    w_code = 16'((32'd1 << move_w) - 32'd1);
    return mv == w_code;
  endfunction

  function automatic logic is_resign(input logic [15:0] mv, input int move_w);
    logic [15:0] w_code;
    w_code = 16'((32'd1 << move_w) - 32'd2);
    return mv == w_code;
  endfunction

endpackage

// File: rtl/go_game_ctrl_if.sv
// rtl/go_game_ctrl_if.sv - start/valid/invalid handshake between go_game_ctrl and the board updater
// Signals: upd_start/upd_move (controller -> updater), upd_valid/upd_invalid/next_board (updater -> controller).
interface go_game_ctrl_if #(
  parameter int N       = 9,
  parameter int COORD_W = $clog2(N)
);
  localparam int MOVE_W = 2 * COORD_W;
  localparam int BW     = 2 * N * N;

  logic              upd_start;
  logic [MOVE_W-1:0] upd_move;
  logic              upd_valid;
  logic              upd_invalid;
  logic [BW-1:0]     next_board;

  modport master (output upd_start, upd_move, input upd_valid, upd_invalid, next_board);
  modport slave  (input upd_start, upd_move, output upd_valid, upd_invalid, next_board);
endinterface

// File: rtl/go_game_ctrl_turn_timer.sv
// rtl/go_game_ctrl_turn_timer.sv - per-turn countdown of tick strobes
// Ports: i_clk, i_reset, i_load (reload to TURN_LIMIT), i_en (counting allowed), i_tick,
//        o_count (ticks left), o_expire (the tick that exhausts the turn).
module go_game_ctrl_turn_timer #(
  parameter int TURN_LIMIT = 60,
  parameter int TL_W       = 6
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_load,
  input  logic            i_en,
  input  logic            i_tick,
  output logic [TL_W-1:0] o_count,
  output logic            o_expire
);
  localparam logic [TL_W-1:0] LP_RELOAD = TL_W'(TURN_LIMIT);

  logic [TL_W-1:0] r_count;

  // A zero limit leaves the count at zero, so it can never reach one and expire.
  assign o_expire = (TURN_LIMIT != 0) && i_en && i_tick && (r_count == TL_W'(1));
  assign o_count  = r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_load) begin
      r_count <= LP_RELOAD;
    end else if (i_en && i_tick && (r_count != '0)) begin
      r_count <= r_count - TL_W'(1);
    end
  end
endmodule

// File: rtl/go_game_ctrl.sv
// rtl/go_game_ctrl.sv - Go game controller: live board, ko snapshot, turn, move count and turn clock
// Ports: i_clk_in, i_reset, i_my_color, i_move_avail, i_move, i_tick_in, upd (updater handshake, master),
//        o_board_bus, o_ko_board, o_turn, o_tx_ready, o_invalid_move, o_move_count, o_time_left,
//        o_game_over, o_end_reason, o_winner, o_state.
module go_game_ctrl #(
  parameter int N          = 9,
  parameter int COORD_W    = $clog2(N),
  parameter int PASS_LIMIT = 2,
  parameter int TURN_LIMIT = 60,
  parameter int CNT_W      = 9,
  localparam int MOVE_W    = 2 * COORD_W,
  localparam int BW        = 2 * N * N,
  localparam int TL_W      = (TURN_LIMIT > 0) ? $clog2(TURN_LIMIT + 1) : 1
) (
  input  logic               i_clk_in,
  input  logic               i_reset,
  input  logic               i_my_color,
  input  logic               i_move_avail,
  input  logic [MOVE_W-1:0]  i_move,
  input  logic               i_tick_in,
  go_game_ctrl_if.master     upd,
  output logic [BW-1:0]      o_board_bus,
  output logic [BW-1:0]      o_ko_board,
  output logic               o_turn,
  output logic               o_tx_ready,
  output logic               o_invalid_move,
  output logic [CNT_W-1:0]   o_move_count,
  output logic [TL_W-1:0]    o_time_left,
  output logic               o_game_over,
  output logic [1:0]         o_end_reason,
  output logic               o_winner,
  output logic [2:0]         o_state
);
  import go_game_ctrl_pkg::*;

  localparam int PC_W = (PASS_LIMIT > 1) ? $clog2(PASS_LIMIT + 1) : 1;

  state_t            r_state;
  logic [BW-1:0]     r_board;
  logic [BW-1:0]     r_ko;
  logic [BW-1:0]     r_next;
  logic [MOVE_W-1:0] r_move;
  logic              r_turn;
  logic              r_start;
  logic              r_tx;
  logic              r_inv;
  logic [PC_W-1:0]   r_pass_cnt;
  logic [CNT_W-1:0]  r_count;
  logic [1:0]        r_reason;
  logic              r_winner;

  logic [COORD_W-1:0] w_row;
  logic [COORD_W-1:0] w_col;
  logic               w_in_range;
  logic               w_is_pass;
  logic               w_is_resign;
  logic               w_last_pass;
  logic [CNT_W-1:0]   w_count_inc;
  logic               w_timer_en;
  logic               w_timer_load;
  logic               w_expire;
  logic [TL_W-1:0]    w_time_left;

  assign w_row       = i_move[MOVE_W-1 -: COORD_W];
  assign w_col       = i_move[COORD_W-1:0];
  assign w_in_range  = (int'(w_row) < N) && (int'(w_col) < N);
  assign w_is_pass   = is_pass(16'(i_move), MOVE_W);
  assign w_is_resign = is_resign(16'(i_move), MOVE_W);
  assign w_last_pass = (int'(r_pass_cnt) + 1 == PASS_LIMIT);
  assign w_count_inc = (r_count == '1) ? r_count : r_count + CNT_W'(1);

  // The clock only runs while a player is thinking or the updater is working.
  assign w_timer_en   = (r_state == S_WAIT) || (r_state == S_CHECK);
  assign w_timer_load = (r_state == S_SEND) || ((r_state == S_PASS) && !w_last_pass);

  go_game_ctrl_turn_timer #(
    .TURN_LIMIT (TURN_LIMIT),
    .TL_W       (TL_W)
  ) u_turn_timer (
    .i_clk    (i_clk_in),
    .i_reset  (i_reset),
    .i_load   (w_timer_load),
    .i_en     (w_timer_en),
    .i_tick   (i_tick_in),
    .o_count  (w_time_left),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk_in) begin
    if (i_reset) begin
      r_state    <= S_WAIT;
      r_board    <= '0;
      r_ko       <= '0;
      r_next     <= '0;
      r_move     <= '0;
      r_turn     <= 1'b0;
      r_start    <= 1'b0;
      r_tx       <= 1'b0;
      r_inv      <= 1'b0;
      r_pass_cnt <= '0;
      r_count    <= '0;
      r_reason   <= END_NONE;
      r_winner   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_tx    <= 1'b0;
      r_inv   <= 1'b0;
      case (r_state)
        S_WAIT: begin
          if (w_expire) begin
            r_state  <= S_OVER;
            r_reason <= END_TIMEOUT;
            r_winner <= ~r_turn;
          end else if (i_move_avail) begin
            if (w_is_pass) begin
              r_state <= S_PASS;
            end else if (w_is_resign) begin
              r_state  <= S_OVER;
              r_reason <= END_RESIGN;
              r_winner <= ~r_turn;
            end else if (!w_in_range) begin
              r_inv <= 1'b1;
            end else begin
              r_move  <= i_move;
              r_start <= 1'b1;
              r_state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          // Timeout outranks the updater; a rejection outranks an acceptance.
          if (w_expire) begin
            r_state  <= S_OVER;
            r_reason <= END_TIMEOUT;
            r_winner <= ~r_turn;
          end else if (upd.upd_invalid) begin
            r_inv   <= 1'b1;
            r_state <= S_WAIT;
          end else if (upd.upd_valid) begin
            // next_board is only guaranteed stable while upd_valid is high.
            r_next  <= upd.next_board;
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_ko       <= r_board;
          r_board    <= r_next;
          r_pass_cnt <= '0;
          r_count    <= w_count_inc;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          r_tx    <= (r_turn == i_my_color);
          r_turn  <= ~r_turn;
          r_state <= S_WAIT;
        end
        S_PASS: begin
          r_count <= w_count_inc;
          if (w_last_pass) begin
            r_state  <= S_OVER;
            r_reason <= END_PASSES;
            r_winner <= 1'b0;
          end else begin
            // A pass lifts any ko restriction, so the snapshot tracks the live board.
            r_pass_cnt <= r_pass_cnt + PC_W'(1);
            r_ko       <= r_board;
            r_tx       <= (r_turn == i_my_color);
            r_turn     <= ~r_turn;
            r_state    <= S_WAIT;
          end
        end
        S_OVER: begin
          r_state <= S_OVER;
        end
        default: begin
          r_state <= S_WAIT;
        end
      endcase
    end
  end

  assign upd.upd_start  = r_start;
  assign upd.upd_move   = r_move;
  assign o_board_bus    = r_board;
  assign o_ko_board     = r_ko;
  assign o_turn         = r_turn;
  assign o_tx_ready     = r_tx;
  assign o_invalid_move = r_inv;
  assign o_move_count   = r_count;
  assign o_time_left    = w_time_left;
  assign o_game_over    = (r_state == S_OVER);
  assign o_end_reason   = r_reason;
  assign o_winner       = r_winner;
  assign o_state        = r_state;
endmodule

// File: tb/tb_go_game_ctrl.sv
// tb/tb_go_game_ctrl.sv - self-checking bench for go_game_ctrl
module tb_go_game_ctrl;
  import go_game_ctrl_pkg::*;

  localparam int N     = 9;
  localparam int MW    = 8;
  localparam int BW    = 2 * N * N;
  localparam int PL    = 2;
  localparam int TL    = 3;
  localparam int CNT_W = 9;
  localparam int TL_W  = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             my_color;
  logic             move_avail;
  logic [MW-1:0]    move;
  logic             tick_in;
  logic [BW-1:0]    board_bus;
  logic [BW-1:0]    ko_board;
  logic             turn;
  logic             tx_ready;
  logic             invalid_move;
  logic [CNT_W-1:0] move_count;
  logic [TL_W-1:0]  time_left;
  logic             game_over;
  logic [1:0]       end_reason;
  logic             winner;
  logic [2:0]       state;

  go_game_ctrl_if #(.N(N)) u_if ();

  go_game_ctrl #(
    .N(N), .PASS_LIMIT(PL), .TURN_LIMIT(TL), .CNT_W(CNT_W)
  ) dut (
    .i_clk_in(clk), .i_reset(reset), .i_my_color(my_color), .i_move_avail(move_avail),
    .i_move(move), .i_tick_in(tick_in), .upd(u_if.master),
    .o_board_bus(board_bus), .o_ko_board(ko_board), .o_turn(turn), .o_tx_ready(tx_ready),
    .o_invalid_move(invalid_move), .o_move_count(move_count), .o_time_left(time_left),
    .o_game_over(game_over), .o_end_reason(end_reason), .o_winner(winner), .o_state(state)
  );

  int    checks = 0;
  int    failures = 0;
  string cur_tag = "init";

  // pulse counters, sampled mid-cycle
  int c_tx = 0, c_inv = 0, c_start = 0;
  always @(negedge clk) begin
    if (tx_ready) c_tx++;
    if (invalid_move) c_inv++;
    if (u_if.upd_start) c_start++;
  end

  // reference model: the game as arrays of cells and plain counters
  logic [1:0] m_board [N*N];
  logic [1:0] m_ko [N*N];
  bit         m_turn, m_over, m_winner;
  int         m_count, m_pass, m_time;
  logic [1:0] m_reason;
  int         e_tx = 0, e_inv = 0, e_start = 0;

  function automatic logic [BW-1:0] pack_board(input bit ko);
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < N*N; i++) v[2*i +: 2] = ko ? m_ko[i] : m_board[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N*N; i++) begin
      m_board[i] = 2'b00;
      m_ko[i] = 2'b00;
    end
    m_turn = 0; m_over = 0; m_winner = 0; m_count = 0; m_pass = 0; m_time = TL; m_reason = 2'b00;
  endtask

  task automatic m_bump_count();
    m_count = (m_count == CMAX) ? CMAX : m_count + 1;
  endtask

  task automatic m_hand_over();
    if (m_turn == my_color) e_tx++;
    m_turn = !m_turn;
    m_time = TL;
  endtask

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s: got 0x%0h expected 0x%0h", cur_tag, name, act, exp);
    end
  endtask

  task automatic check_all();
    #1;
    chk("board", board_bus, pack_board(0));
    chk("ko", ko_board, pack_board(1));
    chk("turn", BW'(turn), BW'(m_turn));
    chk("move_count", BW'(move_count), BW'(m_count));
    chk("game_over", BW'(game_over), BW'(m_over));
    chk("end_reason", BW'(end_reason), BW'(m_reason));
    chk("winner", BW'(winner), BW'(m_winner));
    if (!m_over) chk("time_left", BW'(time_left), BW'(m_time));
    chk("state", BW'(state), BW'(m_over ? S_OVER : S_WAIT));
    chk("tx_pulses", BW'(c_tx), BW'(e_tx));
    chk("inv_pulses", BW'(c_inv), BW'(e_inv));
    chk("start_pulses", BW'(c_start), BW'(e_start));
  endtask

  task automatic do_reset(input bit color);
    @(negedge clk);
    reset = 1; my_color = color; move_avail = 0; tick_in = 0;
    u_if.upd_valid = 0; u_if.upd_invalid = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    m_reset();
  endtask

  // kind: 0 stone, 1 pass, 2 resign, 3 tick; ans: 0 legal, 1 illegal, 2 both strobes
  task automatic do_action(input int kind, input int r, input int c, input int ans, input int k);
    logic [MW-1:0] mv;
    logic [BW-1:0] nb;
    bit            seen;
    int            idx;
    if (kind == 3) begin
      @(negedge clk); tick_in = 1;
      @(negedge clk); tick_in = 0;
      if (!m_over) begin
        if (m_time == 1) begin
          m_over = 1; m_reason = 2'b11; m_winner = !m_turn; m_time = 0;
        end else begin
          m_time--;
        end
      end
      repeat (2) @(negedge clk);
      return;
    end
    case (kind)
      0:       mv = {4'(r), 4'(c)};
      1:       mv = 8'hFF;
      default: mv = 8'hFE;
    endcase
    @(negedge clk); move_avail = 1; move = mv;
    @(negedge clk); move_avail = 0; move = 8'($urandom);
    if (m_over) begin
      repeat (4) @(negedge clk);
      return;
    end
    if (kind == 1) begin
      m_bump_count();
      if (m_pass + 1 == PL) begin
        m_over = 1; m_reason = 2'b01; m_winner = 0;
      end else begin
        m_pass++;
        m_ko = m_board;
        m_hand_over();
      end
      repeat (4) @(negedge clk);
      return;
    end
    if (kind == 2) begin
      m_over = 1; m_reason = 2'b10; m_winner = !m_turn;
      repeat (4) @(negedge clk);
      return;
    end
    if (r >= N || c >= N) begin
      e_inv++;
      repeat (4) @(negedge clk);
      return;
    end
    e_start++;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (u_if.upd_start) seen = 1;
      else @(negedge clk);
    end
    chk("upd_start_seen", BW'(seen), BW'(1));
    chk("upd_move", BW'(u_if.upd_move), BW'(mv));
    idx = r * N + c;
    nb = pack_board(0);
    nb[2*idx +: 2] = m_turn ? 2'b10 : 2'b01;
    repeat (k) @(negedge clk);
    u_if.next_board = nb;
    u_if.upd_valid = (ans != 1);
    u_if.upd_invalid = (ans != 0);
    @(negedge clk);
    u_if.upd_valid = 0; u_if.upd_invalid = 0;
    if (ans == 0) begin
      m_ko = m_board;
      m_board[idx] = m_turn ? 2'b10 : 2'b01;
      m_pass = 0;
      m_bump_count();
      m_hand_over();
    end else begin
      e_inv++;
    end
    repeat (5) @(negedge clk);
  endtask

  typedef struct {
    int rst, color, kind, r, c, ans, k;
    int e_turn, e_count, e_over, e_reason, e_winner, e_dinv, e_dtx, e_cell;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_tx, b_inv;
    reset = 1; my_color = 0; move_avail = 0; move = '0; tick_in = 0;
    u_if.upd_valid = 0; u_if.upd_invalid = 0; u_if.next_board = '0;
    m_reset();

    //            rst col kind r  c  ans k  turn cnt over rsn win dinv dtx cell
    tbl.push_back('{1, 0, 0,   2, 3, 0,  3, 1,   1,  0,   0,  0,  0,   1,  1});
    tbl.push_back('{0, 0, 0,   9, 0, 0,  0, 1,   1,  0,   0,  0,  1,   0, -1});
    tbl.push_back('{0, 0, 0,   4, 4, 2,  1, 1,   1,  0,   0,  0,  1,   0,  0});
    tbl.push_back('{0, 0, 0,   4, 4, 0,  0, 0,   2,  0,   0,  0,  0,   0,  2});
    tbl.push_back('{0, 0, 1,   0, 0, 0,  0, 1,   3,  0,   0,  0,  0,   1, -1});
    tbl.push_back('{0, 0, 0,   0, 0, 0,  2, 0,   4,  0,   0,  0,  0,   0,  2});
    tbl.push_back('{0, 0, 1,   0, 0, 0,  0, 1,   5,  0,   0,  0,  0,   1, -1});
    tbl.push_back('{0, 0, 1,   0, 0, 0,  0, 1,   6,  1,   1,  0,  0,   0, -1});
    tbl.push_back('{0, 0, 0,   1, 1, 0,  0, 1,   6,  1,   1,  0,  0,   0,  0});
    tbl.push_back('{1, 0, 2,   0, 0, 0,  0, 0,   0,  1,   2,  1,  0,   0, -1});
    tbl.push_back('{1, 0, 0,   3, 3, 0,  0, 1,   1,  0,   0,  0,  0,   1,  1});
    tbl.push_back('{0, 0, 3,   0, 0, 0,  0, 1,   1,  0,   0,  0,  0,   0, -1});
    tbl.push_back('{0, 0, 3,   0, 0, 0,  0, 1,   1,  0,   0,  0,  0,   0, -1});
    tbl.push_back('{0, 0, 3,   0, 0, 0,  0, 1,   1,  1,   3,  0,  0,   0, -1});
    tbl.push_back('{1, 1, 0,   2, 3, 0,  1, 1,   1,  0,   0,  0,  0,   0,  1});

    repeat (3) @(negedge clk);
    reset = 0;
    cur_tag = "reset";
    check_all();
    chk("reset_time_left", BW'(time_left), BW'(3));
    chk("reset_state", BW'(state), BW'(0));

    foreach (tbl[i]) begin
      cur_tag = $sformatf("vec%0d", i);
      if (tbl[i].rst != 0) do_reset(tbl[i].color[0]);
      #1;
      b_tx = c_tx; b_inv = c_inv;
      do_action(tbl[i].kind, tbl[i].r, tbl[i].c, tbl[i].ans, tbl[i].k);
      #1;
      chk("v_turn", BW'(turn), BW'(tbl[i].e_turn));
      chk("v_count", BW'(move_count), BW'(tbl[i].e_count));
      chk("v_over", BW'(game_over), BW'(tbl[i].e_over));
      chk("v_reason", BW'(end_reason), BW'(tbl[i].e_reason));
      chk("v_winner", BW'(winner), BW'(tbl[i].e_winner));
      chk("v_dinv", BW'(c_inv - b_inv), BW'(tbl[i].e_dinv));
      chk("v_dtx", BW'(c_tx - b_tx), BW'(tbl[i].e_dtx));
      if (tbl[i].e_cell >= 0)
        chk("v_cell", BW'(board_bus[2*(tbl[i].r*N+tbl[i].c) +: 2]), BW'(tbl[i].e_cell));
      check_all();
    end

    // reset after a timeout restores every reset value
    cur_tag = "reset_after_over";
    do_reset(0);
    check_all();

    // reset while the updater is busy; its late answers must be ignored
    cur_tag = "reset_mid_check";
    @(negedge clk); move_avail = 1; move = 8'h22;
    @(negedge clk); move_avail = 0;
    e_start++;
    reset = 1;
    @(negedge clk); reset = 0;
    m_reset();
    u_if.next_board = {BW{1'b1}}; u_if.upd_valid = 1;
    @(negedge clk); u_if.upd_valid = 0; u_if.upd_invalid = 1;
    @(negedge clk); u_if.upd_invalid = 0;
    repeat (4) @(negedge clk);
    check_all();

    // randomized games against the model
    do_reset(1'($urandom_range(0, 1)));
    for (int n = 0; n < 300; n++) begin
      int sel, r, c, ans, k;
      cur_tag = $sformatf("rnd%0d", n);
      sel = $urandom_range(0, 99);
      k = $urandom_range(0, 3);
      r = $urandom_range(0, N - 1);
      c = $urandom_range(0, N - 1);
      if (sel < 60) begin
        if (m_board[r*N+c] != 2'b00) ans = 1;
        else if ($urandom_range(0, 99) < 85) ans = 0;
        else ans = $urandom_range(1, 2);
        do_action(0, r, c, ans, k);
      end else if (sel < 68) begin
        if ($urandom_range(0, 1) == 1) r = $urandom_range(N, 12);
        else c = $urandom_range(N, 12);
        do_action(0, r, c, 0, k);
      end else if (sel < 80) begin
        do_action(1, 0, 0, 0, 0);
      end else if (sel < 82) begin
        do_action(2, 0, 0, 0, 0);
      end else if (sel < 98) begin
        do_action(3, 0, 0, 0, 0);
      end else begin
        do_reset(1'($urandom_range(0, 1)));
      end
      check_all();
      if (m_over) begin
        do_action($urandom_range(0, 3), r, c, 0, 0);
        check_all();
        do_reset(1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
